// File: rtl/mem_twoport_pipe.sv
// ============================================================================
// mem_twoport_pipe : 1W/1R synchronous memory, registered read, clear engine
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_twoport_pipe #(
  parameter int WIDTH   = 20,
  parameter int DEPTH   = 512,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int OUT_REG = 1,
  parameter int BYPASS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] wa,
  input  logic              write,
  input  logic [WIDTH-1:0]  d,
  input  logic [ADDR_W-1:0] ra,
  input  logic              ren,
  input  logic              clear,
  output logic [WIDTH-1:0]  q,
  output logic              rvalid,
  output logic              busy
);

  localparam logic [0:0]        c_st_ready = 1'b0;
  localparam logic [0:0]        c_st_clear = 1'b1;
  localparam logic [ADDR_W:0]   c_depth    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_last     = ADDR_W'(DEPTH - 1);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_q1;
  logic              r_v1;

  logic              w_ready;
  logic              w_wr_ok;
  logic              w_rd_acc;
  logic              w_rd_inrange;
  logic              w_collide;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_wa;
  logic [WIDTH-1:0]  w_mem_wd;
  logic [WIDTH-1:0]  w_rd_data;

  assign w_ready      = (r_state == c_st_ready);
  assign w_wr_ok      = w_ready && write && ({1'b0, wa} < c_depth);
  assign w_rd_acc     = w_ready && ren;
  assign w_rd_inrange = ({1'b0, ra} < c_depth);
  assign w_collide    = w_wr_ok && (wa == ra);
  assign busy         = (r_state == c_st_clear);

  // The clear engine owns the write port while busy.
  assign w_mem_we = busy || w_wr_ok;
  assign w_mem_wa = busy ? r_ptr : wa;
  assign w_mem_wd = busy ? '0 : d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_clear;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        c_st_clear: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == c_last) begin
            r_state <= c_st_ready;
            r_ptr   <= '0;
          end
        end
        default: begin
          if (clear) begin
            r_state <= c_st_clear;
            r_ptr   <= '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_wa] <= w_mem_wd;
  end

  always_comb begin
    w_rd_data = '0;
    if (w_rd_inrange) begin
      if ((BYPASS != 0) && w_collide) w_rd_data = d;
      else                            w_rd_data = r_mem[ra];
    end
  end

  // Data registers load only on valid results so q holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_q1 <= '0;
    end else begin
      r_v1 <= w_rd_acc;
      if (w_rd_acc) r_q1 <= w_rd_data;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] r_q2;
      logic             r_v2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v2 <= 1'b0;
          r_q2 <= '0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) r_q2 <= r_q1;
        end
      end

      assign q      = r_q2;
      assign rvalid = r_v2;
    end else begin : g_no_out_reg
      assign q      = r_q1;
      assign rvalid = r_v1;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_mem_twoport_pipe.sv
// ============================================================================
// tb_mem_twoport_pipe : scoreboard bench, DUT0 512/OUT_REG=1/BYPASS=1,
//                       DUT1 300/OUT_REG=0/BYPASS=0
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_twoport_pipe;

  localparam int AW = 9;
  localparam int W  = 20;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [AW-1:0] wa [2];
  logic [AW-1:0] ra [2];
  logic [W-1:0]  d  [2];
  logic [W-1:0]  q  [2];
  logic          write [2];
  logic          ren   [2];
  logic          clear [2];
  logic          rvalid[2];
  logic          busy  [2];

  exp_t sbq0[$];
  exp_t sbq1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   ca, cb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_twoport_pipe #(.WIDTH(20), .DEPTH(512), .OUT_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .wa(wa[0]), .write(write[0]), .d(d[0]),
    .ra(ra[0]), .ren(ren[0]), .clear(clear[0]), .q(q[0]),
    .rvalid(rvalid[0]), .busy(busy[0])
  );

  mem_twoport_pipe #(.WIDTH(20), .DEPTH(300), .OUT_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .wa(wa[1]), .write(write[1]), .d(d[1]),
    .ra(ra[1]), .ren(ren[1]), .clear(clear[1]), .q(q[1]),
    .rvalid(rvalid[1]), .busy(busy[1])
  );

  function automatic int dep(input int k);
    return (k == 0) ? 512 : 300;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input logic [W-1:0] v);
    exp_t e;
    e.data = v;
    e.due  = cyc + lat(k);
    if (k == 0) sbq0.push_back(e);
    else        sbq1.push_back(e);
  endtask

  task automatic pop(input int k);
    if (k == 0) void'(sbq0.pop_front());
    else        void'(sbq1.pop_front());
  endtask

  // Monitor: every rvalid must match the oldest expectation, on its due cycle.
  task automatic mon(input int k);
    exp_t e;
    int   n;
    n = (k == 0) ? sbq0.size() : sbq1.size();
    if (n > 0) e = (k == 0) ? sbq0[0] : sbq1[0];
    if (rvalid[k]) begin
      if (n == 0) begin
        check($sformatf("dut%0d_unexpected_rvalid", k), 32'd1, 32'd0);
      end else begin
        pop(k);
        check($sformatf("dut%0d_q", k), 32'(q[k]), 32'(e.data));
        check($sformatf("dut%0d_rvalid_cycle", k), 32'(cyc), 32'(e.due));
      end
    end else if (n > 0 && e.due <= cyc) begin
      pop(k);
      check($sformatf("dut%0d_rvalid_missing", k), 32'd0, 32'd1);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // One cycle of stimulus; call at a negedge, returns at the next negedge.
  task automatic op(input int k, input bit we, input int a_w, input logic [W-1:0] dd,
                    input bit re, input int a_r, input logic [W-1:0] ev, input bit clr);
    wa[k]    = AW'(a_w);
    write[k] = we;
    d[k]     = dd;
    ren[k]   = re;
    ra[k]    = AW'(a_r);
    clear[k] = clr;
    if (re && !busy[k]) push(k, ev);
    @(negedge clk);
    write[k] = 1'b0;
    ren[k]   = 1'b0;
    clear[k] = 1'b0;
  endtask

  task automatic count_busy(input int k, output int cnt);
    cnt = 0;
    while (busy[k] && cnt < 5000) begin
      cnt++;
      @(negedge clk);
    end
    write[k] = 1'b0;
    ren[k]   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wa[k] = '0; ra[k] = '0; d[k] = '0;
      write[k] = 1'b0; ren[k] = 1'b0; clear[k] = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("dut%0d_reset_busy", k), 32'(busy[k]), 32'd1);
      check($sformatf("dut%0d_reset_rvalid", k), 32'(rvalid[k]), 32'd0);
      check($sformatf("dut%0d_reset_q", k), 32'(q[k]), 32'd0);
    end

    // Hold write/read requests through the whole post-reset clear.
    for (int k = 0; k < 2; k++) begin
      wa[k] = AW'(5); ra[k] = AW'(5); d[k] = 20'hFFFFF;
      write[k] = 1'b1; ren[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fork
      count_busy(0, ca);
      count_busy(1, cb);
    join
    check("dut0_busy_cycles", 32'(ca), 32'd512);
    check("dut1_busy_cycles", 32'(cb), 32'd300);

    op(0, 0, 0, 0, 1, 0,   0, 0);
    op(0, 0, 0, 0, 1, 255, 0, 0);
    op(0, 0, 0, 0, 1, 511, 0, 0);
    op(0, 0, 0, 0, 1, 5,   0, 0);
    op(1, 0, 0, 0, 1, 0,   0, 0);
    op(1, 0, 0, 0, 1, 255, 0, 0);
    op(1, 0, 0, 0, 1, 299, 0, 0);
    op(1, 0, 0, 0, 1, 5,   0, 0);

    // Sweep: write word i while reading back word i-1 written the cycle before.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i <= dep(k); i++) begin
        op(k, i < dep(k), i, W'(i + 512), i > 0, i - 1, W'(i - 1 + 512), 0);
      end
    end

    for (int k = 0; k < 2; k++) begin
      for (int i = 100; i < 116; i++) op(k, 0, 0, 0, 1, i, W'(i + 512), 0);
      repeat (3) @(negedge clk);
    end

    for (int k = 0; k < 2; k++) begin
      op(k, 1, 7, 20'h00ABC, 0, 0, 0, 0);
      op(k, 1, 7, 20'h12345, 1, 7, (k == 0) ? 20'h12345 : 20'h00ABC, 0);
      op(k, 0, 0, 0, 1, 7, 20'h12345, 0);
    end

    op(1, 1, 310, 20'hFFFFF, 0, 0,   0, 0);
    op(1, 0, 0,   0,         1, 310, 0, 0);
    op(1, 0, 0,   0,         1, 299, W'(299 + 512), 0);

    // Clear while reads are in flight, plus a read in the clear cycle itself.
    op(0, 0, 0, 0, 1, 100, W'(612), 0);
    op(0, 0, 0, 0, 1, 101, W'(613), 1);
    count_busy(0, ca);
    check("dut0_clear_busy_cycles", 32'(ca), 32'd512);
    op(0, 0, 0, 0, 1, 100, 0, 0);
    repeat (3) @(negedge clk);

    // Async reset with two reads in flight; those results must vanish.
    op(0, 1, 20, 20'hAAAAA, 0, 0, 0, 0);
    ra[0]  = AW'(20);
    ren[0] = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    check("dut0_inflight_rvalid", 32'(rvalid[0]), 32'd1);
    check("dut0_inflight_q", 32'(q[0]), 32'hAAAAA);
    rst_n = 1'b0;
    #1;
    check("dut0_async_rst_rvalid", 32'(rvalid[0]), 32'd0);
    check("dut0_async_rst_q", 32'(q[0]), 32'd0);
    check("dut0_async_rst_busy", 32'(busy[0]), 32'd1);
    ren[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fork
      count_busy(0, ca);
      count_busy(1, cb);
    join
    check("dut0_rst2_busy_cycles", 32'(ca), 32'd512);
    op(0, 0, 0, 0, 1, 20, 0, 0);

    repeat (5) @(negedge clk);
    check("dut0_scoreboard_empty", 32'(sbq0.size()), 32'd0);
    check("dut1_scoreboard_empty", 32'(sbq1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
